// File: rtl/rf_pkg.sv
// Shared constants for the register scoreboard file.
package rf_pkg;

    localparam int unsigned RF_NREGS         = 8;
    localparam int unsigned RF_ADDR_W        = 3;
    localparam int unsigned RF_DEFAULT_WIDTH = 16;

endpackage : rf_pkg

// File: rtl/reg_scoreboard_file_if.sv
// Writeback, issue and read-port bundle for reg_scoreboard_file.
interface reg_scoreboard_file_if
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH = RF_DEFAULT_WIDTH
);

    logic                 wr_en;
    logic [RF_NREGS-1:0]  wr_sel;
    logic [WIDTH-1:0]     wr_data;
    logic                 iss_valid;
    logic [RF_NREGS-1:0]  iss_sel;
    logic [RF_ADDR_W-1:0] rd_addr1;
    logic [RF_ADDR_W-1:0] rd_addr2;
    logic [WIDTH-1:0]     rd_data1;
    logic [WIDTH-1:0]     rd_data2;
    logic                 hazard1;
    logic                 hazard2;
    logic [RF_NREGS-1:0]  busy;
    logic                 err;

    modport master (
        output wr_en, wr_sel, wr_data, iss_valid, iss_sel, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, hazard1, hazard2, busy, err
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, iss_valid, iss_sel, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, hazard1, hazard2, busy, err
    );

endinterface : reg_scoreboard_file_if

// File: rtl/rf_onehot_chk.sv
// One-hot validity check and index encode of an 8-bit select vector.
module rf_onehot_chk
    import rf_pkg::*;
(
    input  logic [RF_NREGS-1:0]  sel_i,
    output logic                 is_onehot_o,
    output logic [RF_ADDR_W-1:0] index_o
);

    // Non-zero with exactly one bit set; index is only meaningful when one-hot.
    always_comb begin
        is_onehot_o = (sel_i != '0) && ((sel_i & (sel_i - RF_NREGS'(1))) == '0);
        index_o     = '0;
        for (int i = 0; i < int'(RF_NREGS); i++) begin
            if (sel_i[i]) begin
                index_o = RF_ADDR_W'(i);
            end
        end
    end

endmodule : rf_onehot_chk

// File: rtl/reg_scoreboard_file.sv
// 8-entry register file with a single-bit-per-register write scoreboard
// and a sticky select-error flag.
// Optional: define RF_BYPASS_EN to forward same-cycle writeback data to
// the read ports (and mask their hazard) when the addresses match.
module reg_scoreboard_file
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH = RF_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_scoreboard_file_if.slave   bus
);

    logic [RF_NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [RF_NREGS-1:0]            busy_q, busy_d;
    logic                           err_q,  err_d;

    logic                 wr_onehot, iss_onehot;
    logic [RF_ADDR_W-1:0] wr_idx,    iss_idx;
    logic                 wr_ok,     iss_ok;

    rf_onehot_chk u_wr_chk (
        .sel_i       (bus.wr_sel),
        .is_onehot_o (wr_onehot),
        .index_o     (wr_idx)
    );

    rf_onehot_chk u_iss_chk (
        .sel_i       (bus.iss_sel),
        .is_onehot_o (iss_onehot),
        .index_o     (iss_idx)
    );

    // Qualified writeback/issue; reset masks them so nothing leaks through bypass.
    assign wr_ok  = bus.wr_en     & wr_onehot  & ~rst;
    assign iss_ok = bus.iss_valid & iss_onehot & ~rst;

    // Next-state: write data, clear-on-write then set-on-issue so issue wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        err_d  = err_q | (bus.wr_en & ~wr_onehot) | (bus.iss_valid & ~iss_onehot);
        if (wr_ok) begin
            regs_d[wr_idx] = bus.wr_data;
            busy_d[wr_idx] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_idx] = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // Combinational read ports with optional same-cycle writeback forwarding.
    always_comb begin
        bus.rd_data1 = regs_q[bus.rd_addr1];
        bus.rd_data2 = regs_q[bus.rd_addr2];
        bus.hazard1  = busy_q[bus.rd_addr1];
        bus.hazard2  = busy_q[bus.rd_addr2];
`ifdef RF_BYPASS_EN
        if (wr_ok && (wr_idx == bus.rd_addr1)) begin
            bus.rd_data1 = bus.wr_data;
            bus.hazard1  = 1'b0;
        end
        if (wr_ok && (wr_idx == bus.rd_addr2)) begin
            bus.rd_data2 = bus.wr_data;
            bus.hazard2  = 1'b0;
        end
`endif
    end

    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule : reg_scoreboard_file

// File: doc/reg_scoreboard_file.md
REG_SCOREBOARD_FILE -- requirements
Module: reg_scoreboard_file

Interface
REQ-001 Parameter: WIDTH, default 16, data width of each register.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: wr_en  input  1  writeback valid.
REQ-005 Port: wr_sel  input  8  one-hot decoded writeback destination; bit i selects R[i].
REQ-006 Port: wr_data  input  WIDTH  writeback data.
REQ-007 Port: iss_valid  input  1  an instruction with a destination register issues this cycle.
REQ-008 Port: iss_sel  input  8  one-hot decoded destination of the issuing instruction.
REQ-009 Port: rd_addr1, rd_addr2  input  3 each  read-port register numbers.
REQ-010 Port: rd_data1, rd_data2  output  WIDTH each  read data.
REQ-011 Port: hazard1, hazard2  output  1 each  read port sources a register with an outstanding write.
REQ-012 Port: busy  output  8  scoreboard; bit i set means R[i] has an outstanding write.
REQ-013 Port: err  output  1  sticky select error flag.

Function
REQ-014 Storage SHALL be 8 registers R[0..7] of WIDTH bits; R[0] is ordinary (not hardwired).
REQ-015 Write: at a clk edge with wr_en=1 and wr_sel exactly one-hot, R[i] <= wr_data for the set bit i.
REQ-016 wr_en=1 with wr_sel zero or multi-hot SHALL write nothing, clear no busy bit, and set err.
REQ-017 Reads SHALL be combinational: rd_dataN = R[rd_addrN]; both ports may address the same register.
REQ-018 Scoreboard: iss_valid=1 with one-hot iss_sel sets busy[i] at the clk edge.
REQ-019 A valid write clears busy[i] for its selected register at the clk edge.
REQ-020 Same register set by issue and cleared by write in one cycle: busy[i] ends 1 (issue wins).
REQ-021 Issue and write to different registers in one cycle: both updates take effect.
REQ-022 iss_valid=1 with iss_sel zero or multi-hot SHALL change no busy bit and SHALL set err.
REQ-023 Issue to an already-busy register: busy stays 1; single-bit scoreboard, no count.
REQ-024 hazardN = busy[rd_addrN], except as modified by REQ-029.
REQ-025 err, once set, holds 1 until reset.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force all R[i]=0, busy=0x00 and err=0.
REQ-027 Outputs during/after reset: rd_data1=rd_data2=0, hazard1=hazard2=0.
REQ-028 Reset asserted mid-operation SHALL discard any same-cycle write or issue; the first update occurs on the first clk edge after rst deasserts.

Configuration
REQ-029 With RF_BYPASS_EN defined: if a valid write selects rd_addrN in the current cycle, rd_dataN = wr_data and hazardN = 0 in that same cycle.
REQ-030 Without RF_BYPASS_EN: reads return the pre-write value, hazardN = busy[rd_addrN], and the new value is visible from the next cycle.

Structure
REQ-031 Shared package rf_pkg SHALL hold RF_NREGS=8, RF_ADDR_W=3 and the default data width constant.
REQ-032 One sub-module, rf_onehot_chk (8-bit in; is_onehot and index[2:0] out), SHALL be instantiated twice, once for wr_sel and once for iss_sel.

Verification
REQ-033 Reset: rst pulse between edges -> busy=0x00, err=0, all reads 0, without a clk edge.
REQ-034 Issue then write: iss_sel=0x08 at cycle 1 -> busy=0x08, hazard1=1 for rd_addr1=3. Then wr_sel=0x08, wr_data=0xBEEF at cycle 4 -> busy=0x00 and rd_data1=0xBEEF from cycle 5.
REQ-035 Bypass: wr_sel=0x20, wr_data=0x1234, rd_addr2=5 in the same cycle:
- with RF_BYPASS_EN: rd_data2=0x1234 and hazard2=0 in that cycle.
- without it: the old value in that cycle and 0x1234 in the next.
REQ-036 Collision: iss_sel=0x02 and wr_sel=0x02 in the same cycle -> R[1] written and busy[1]=1 afterwards. Next, iss_sel=0x01 with wr_sel=0x04 -> busy=0x03.
REQ-037 Bad select: wr_en=1 with wr_sel=0x03 -> no register changes and err=1 stays set. Then iss_valid=1 with iss_sel=0x00 -> busy unchanged.
REQ-038 Mid-operation reset: rst asserted with wr_en=1 and wr_sel=0x80 pending -> R[7]=0 and busy=0x00 after rst deasserts.
